// File: rtl/ram_wide_port.sv
// Wide-element sequencer in front of a single-port word RAM.
// Ports: clk, rst (sync, active-high), start/op/idx/data_in request,
// data_out/busy/done status, mem_rd/mem_wr/mem_addr/mem_din/mem_dout
// toward genram.
module ram_wide_port #(
  parameter  int AW  = 6,
  parameter  int DW  = 64,
  parameter  int LNW = 2,
  parameter  int IW  = AW - LNW,
  localparam int NW  = 1 << LNW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [IW-1:0]    idx,
  input  logic [NW*DW-1:0] data_in,
  output logic [NW*DW-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NW*DW-1:0] wdata_q, wdata_d;
  logic [LNW-1:0]   k_q, k_d;
  logic [LNW-1:0]   k_nx;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    din_q, din_d;
  logic [NW*DW-1:0] dout_q, dout_d;
  // A read sampled by the RAM at this edge returns data next cycle;
  // remember which slice it belongs to.
  logic             cap_vld_q, cap_vld_d;
  logic [LNW-1:0]   cap_idx_q, cap_idx_d;

  assign k_nx = k_q + LNW'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    k_d       = k_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    cap_vld_d = rd_q;
    cap_idx_d = addr_q[LNW-1:0];
    dout_d    = dout_q;

    if (cap_vld_q) begin
      dout_d[cap_idx_q*DW +: DW] = mem_dout;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          op_d    = op;
          idx_d   = idx;
          wdata_d = data_in;
          k_d     = '0;
          busy_d  = 1'b1;
          rd_d    = ~op;
          wr_d    = op;
          addr_d  = {idx, {LNW{1'b0}}};
          if (op) begin
            din_d = data_in[DW-1:0];
          end
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        if (k_q == LNW'(NW - 1)) begin
          state_d = op_q ? DONE : DRAIN;
          done_d  = op_q;
        end else begin
          k_d    = k_nx;
          rd_d   = ~op_q;
          wr_d   = op_q;
          addr_d = {idx_q, k_nx};
          if (op_q) begin
            din_d = wdata_q[k_nx*DW +: DW];
          end
        end
      end
      DRAIN: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_rd   = rd_q;
  assign mem_wr   = wr_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: tb/tb_ram_wide_port.sv
// Bench for ram_wide_port with an attached genram-like word RAM.
// Vector table, scoreboard queue and hand-written corner sequences.
module tb_ram_wide_port;

  localparam int AW  = 6;
  localparam int DW  = 64;
  localparam int LNW = 2;
  localparam int NW  = 4;
  localparam int IW  = 4;
  localparam int EW  = NW * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [IW-1:0] idx = '0;
  logic [EW-1:0] data_in = '0;
  logic [EW-1:0] data_out;
  logic          busy, done, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  ram_wide_port #(.AW(AW), .DW(DW), .LNW(LNW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .idx(idx),
    .data_in(data_in), .data_out(data_out), .busy(busy),
    .done(done), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ram [64];
  logic [DW-1:0] shadow [64];

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;
  acc_t acc_q[$];

  typedef struct {
    logic          op;
    logic [IW-1:0] idx;
    logic [EW-1:0] data;
    int            lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          op;
    logic [IW-1:0] idx;
    logic [EW-1:0] d;
    int            lat;
  } vec_t;

  logic [EW-1:0] hold = '0;

  function automatic logic [DW-1:0] init_word(input int a);
    return 64'hF00D_0000_0000_0000 | (64'(a) * 64'h0000_0101_0001_0011);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_rd || mem_wr) begin
      acc_t e;
      e.w = mem_wr;
      e.a = mem_addr;
      e.d = mem_din;
      acc_q.push_back(e);
      tests++;
      if (mem_rd && mem_wr) begin
        fails++;
        $display("FAIL rd_wr_excl: both strobes high at addr %0d", mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [EW-1:0] act,
                     input logic [EW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] elem(input logic [IW-1:0] ix);
    logic [EW-1:0] v;
    logic [LNW-1:0] w;
    v = '0;
    for (int i = 0; i < NW; i++) begin
      w = i[LNW-1:0];
      v[i*DW +: DW] = shadow[{ix, w}];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer starting in the current (idle) cycle and
  // returns in the idle cycle that follows done.
  task automatic run_xfer(input logic o, input logic [IW-1:0] ix,
                          input logic [EW-1:0] d, input int lat);
    exp_t e;
    int n;
    logic seen;
    logic [LNW-1:0] w;
    e.op = o;
    e.idx = ix;
    e.lat = lat;
    if (o) begin
      for (int i = 0; i < NW; i++) begin
        w = i[LNW-1:0];
        shadow[{ix, w}] = d[i*DW +: DW];
      end
      e.data = d;
    end else begin
      e.data = elem(ix);
    end
    sb.push_back(e);
    acc_q.delete();
    start = 1'b1;
    op = o;
    idx = ix;
    data_in = d;
    tick();
    start = 1'b0;
    op = 1'b0;
    data_in = '0;
    n = 1;
    seen = 1'b0;
    while (n <= 20 && !seen) begin
      chk("busy", EW'(busy), EW'(1));
      if (o || n <= 2) chk("dout_hold", data_out, hold);
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done");
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("latency", EW'(n), EW'(e.lat));
      if (!e.op) begin
        chk("data_out", data_out, e.data);
        hold = e.data;
      end
      chk("acc_count", EW'(acc_q.size()), EW'(NW));
      for (int i = 0; i < NW && i < acc_q.size(); i++) begin
        w = i[LNW-1:0];
        chk("acc_addr", EW'(acc_q[i].a), EW'({ix, w}));
        chk("acc_wr", EW'(acc_q[i].w), EW'(o));
        if (o) chk("acc_data", EW'(acc_q[i].d), EW'(d[i*DW +: DW]));
      end
    end
    tick();
    chk("idle_after", EW'({busy, done}), EW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    logic [EW-1:0] nd;
    int n;
    logic seen;

    tbl[0] = '{1'b1, 4'd3, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5};
    tbl[1] = '{1'b0, 4'd3, '0, 6};
    tbl[2] = '{1'b1, 4'd15, {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                             64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000}, 5};
    tbl[3] = '{1'b0, 4'd15, '0, 6};
    tbl[4] = '{1'b0, 4'd14, '0, 6};
    tbl[5] = '{1'b0, 4'd0, '0, 6};
    tbl[6] = '{1'b1, 4'd0, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}, 5};
    tbl[7] = '{1'b0, 4'd3, '0, 6};
    tbl[8] = '{1'b0, 4'd0, '0, 6};

    for (int a = 0; a < 64; a++) begin
      ram[a] = init_word(a);
      shadow[a] = init_word(a);
    end

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ctrl", EW'({busy, done, mem_rd, mem_wr}), EW'(0));
    chk("rst_addr", EW'(mem_addr), EW'(0));
    chk("rst_din", EW'(mem_din), EW'(0));
    chk("rst_dout", data_out, '0);
    acc_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctrl", EW'({busy, done, mem_rd, mem_wr}), EW'(0));
    end
    chk("idle_acc", EW'(acc_q.size()), EW'(0));

    for (int i = 0; i < 9; i++) begin
      run_xfer(tbl[i].op, tbl[i].idx, tbl[i].d, tbl[i].lat);
    end

    // start held high every cycle of a fetch with a changing idx
    acc_q.delete();
    start = 1'b1;
    op = 1'b0;
    idx = 4'd5;
    tick();
    n = 1;
    seen = 1'b0;
    while (n <= 20 && !seen) begin
      idx = IW'(5 + n);
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    tick();
    start = 1'b0;
    chk("sec_seen", EW'(seen), EW'(1));
    chk("sec_latency", EW'(n), EW'(6));
    chk("sec_data", data_out, elem(4'd5));
    chk("sec_ignored", EW'(busy), EW'(0));
    chk("sec_acc_count", EW'(acc_q.size()), EW'(NW));
    for (int i = 0; i < NW && i < acc_q.size(); i++) begin
      chk("sec_acc_addr", EW'(acc_q[i].a), EW'(20 + i));
    end
    hold = elem(4'd5);
    run_xfer(1'b0, 4'd9, '0, 6);

    // reset during the first write cycle of a store to idx 1
    nd = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
          64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    acc_q.delete();
    start = 1'b1;
    op = 1'b1;
    idx = 4'd1;
    data_in = nd;
    tick();
    start = 1'b0;
    op = 1'b0;
    data_in = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ctrl", EW'({busy, done, mem_rd, mem_wr}), EW'(0));
    chk("mid_rst_addr", EW'(mem_addr), EW'(0));
    chk("mid_rst_din", EW'(mem_din), EW'(0));
    chk("mid_rst_dout", data_out, '0);
    chk("mid_rst_acc", EW'(acc_q.size()), EW'(1));
    if (acc_q.size() > 0) begin
      chk("mid_rst_addr4", EW'(acc_q[0].a), EW'(4));
      chk("mid_rst_w0", EW'(acc_q[0].d), EW'(nd[DW-1:0]));
    end
    shadow[4] = nd[DW-1:0];
    hold = '0;
    tick();
    run_xfer(1'b0, 4'd1, '0, 6);

    // back-to-back fetches
    run_xfer(1'b0, 4'd0, '0, 6);
    run_xfer(1'b0, 4'd1, '0, 6);

    for (int a = 0; a < 64; a++) begin
      chk("ram_final", EW'(ram[a]), EW'(shadow[a]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
